// File: rtl/feet_bcd_formatter.sv
// rtl/feet_bcd_formatter.sv - Q(INT_W).4 feet value to packed BCD integer digits plus a tenths digit
module feet_bcd_formatter #(
  parameter int INT_W   = 14,
  parameter int NUM_DIG = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INT_W+3:0]       feet_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [4*NUM_DIG-1:0]   bcd_int,
  output logic [3:0]             bcd_tenth,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int CNT_W = $clog2(INT_W + 1);
  localparam int BCD_W = 4 * NUM_DIG;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t             state_q, state_d;
  logic [INT_W-1:0]   int_q, int_d;             // integer bits still to be shifted in
  logic [BCD_W-1:0]   work_q, work_d;           // double-dabble working digits
  logic [CNT_W-1:0]   cnt_q, cnt_d;             // shifts completed so far
  logic [3:0]         tenth_work_q, tenth_work_d;
  logic [BCD_W-1:0]   bcd_int_q, bcd_int_d;     // published result, held until next DONE entry
  logic [3:0]         bcd_tenth_q, bcd_tenth_d;

  logic [7:0]         frac_x10;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   shifted;
  logic               last_shift;

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      int_q        <= '0;
      work_q       <= '0;
      cnt_q        <= '0;
      tenth_work_q <= '0;
      bcd_int_q    <= '0;
      bcd_tenth_q  <= '0;
    end else begin
      state_q      <= state_d;
      int_q        <= int_d;
      work_q       <= work_d;
      cnt_q        <= cnt_d;
      tenth_work_q <= tenth_work_d;
      bcd_int_q    <= bcd_int_d;
      bcd_tenth_q  <= bcd_tenth_d;
    end
  end

  assign last_shift = (cnt_q == CNT_W'(INT_W - 1));

  // Next-state: accept in IDLE, one shift per CONV cycle, hold DONE until the consumer takes it
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = CONV;
      CONV:    if (last_shift) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Datapath: capture, add-3 then shift, publish the finished digits on the final shift
  always_comb begin
    frac_x10     = 8'({4'b0000, feet_in[3:0]} * 8'd10);
    adj          = work_q;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end
    shifted      = {adj[BCD_W-2:0], int_q[INT_W-1]};

    int_d        = int_q;
    work_d       = work_q;
    cnt_d        = cnt_q;
    tenth_work_d = tenth_work_q;
    bcd_int_d    = bcd_int_q;
    bcd_tenth_d  = bcd_tenth_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          int_d        = feet_in[INT_W+3:4];
          work_d       = '0;
          cnt_d        = '0;
          // floor(frac * 10 / 16): the top nibble of frac*10
          tenth_work_d = frac_x10[7:4];
        end
      end
      CONV: begin
        work_d = shifted;
        int_d  = {int_q[INT_W-2:0], 1'b0};
        cnt_d  = last_shift ? '0 : cnt_q + CNT_W'(1);
        if (last_shift) begin
          bcd_int_d   = shifted;
          bcd_tenth_d = tenth_work_q;
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded purely from state and registers
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == CONV);
    out_valid = (state_q == DONE);
    bcd_int   = bcd_int_q;
    bcd_tenth = bcd_tenth_q;
  end

endmodule

// File: tb/tb_feet_bcd_formatter.sv
// tb/tb_feet_bcd_formatter.sv - scoreboard bench for feet_bcd_formatter
module tb_feet_bcd_formatter;

  localparam int INT_W   = 14;
  localparam int NUM_DIG = 5;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [INT_W+3:0]      feet_in = '0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [4*NUM_DIG-1:0]  bcd_int;
  logic [3:0]            bcd_tenth;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic                  busy;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];
  logic [19:0] got_int;
  logic [3:0]  got_tenth;

  feet_bcd_formatter #(.INT_W(INT_W), .NUM_DIG(NUM_DIG)) dut (
    .clk(clk), .rst_n(rst_n), .feet_in(feet_in), .in_valid(in_valid),
    .in_ready(in_ready), .bcd_int(bcd_int), .bcd_tenth(bcd_tenth),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits by repeated division, tenths by integer arithmetic
  function automatic logic [23:0] model(input logic [17:0] f);
    int ip;
    int fr;
    logic [19:0] b;
    ip = int'(f[17:4]);
    fr = int'(f[3:0]);
    b  = '0;
    for (int d = 0; d < 5; d++) begin
      b[4*d +: 4] = 4'(ip % 10);
      ip = ip / 10;
    end
    return {b, 4'((fr * 10) / 16)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_result(input string tag, input int budget);
    int n;
    logic [23:0] e;
    n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    end else if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      got_int   = bcd_int;
      got_tenth = bcd_tenth;
      check_eq({tag, "_int"},   32'(bcd_int),   32'(e[23:4]));
      check_eq({tag, "_tenth"}, 32'(bcd_tenth), 32'(e[3:0]));
    end
  endtask

  // Single conversion with out_ready already high; returns in IDLE
  task automatic run_one(input string tag, input logic [17:0] v);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    feet_in  = v;
    in_valid = 1'b1;
    exp_q.push_back(model(v));
    tick();
    in_valid = 1'b0;
    wait_result(tag, 40);
    tick();
  endtask

  initial begin
    int prev_t;
    int t;
    int accepted;
    int results;
    logic prev_busy;
    logic [17:0] vals [3];

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready",  32'(in_ready),  32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy",      32'(busy),      32'd0);
    check_eq("rst_bcd_int",   32'(bcd_int),   32'd0);
    check_eq("rst_bcd_tenth", 32'(bcd_tenth), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // 1 m = 52: counting the accepting edge as edge 1, out_valid appears after edge 15
    feet_in  = 18'd52;
    in_valid = 1'b1;
    exp_q.push_back(model(18'd52));
    tick();
    in_valid = 1'b0;
    check_eq("t52_busy",     32'(busy),     32'd1);
    check_eq("t52_in_ready", 32'(in_ready), 32'd0);
    for (int k = 2; k <= 15; k++) begin
      tick();
      if (k == 14) check_eq("t52_valid_e14", 32'(out_valid), 32'd0);
    end
    check_eq("t52_valid_e15", 32'(out_valid), 32'd1);
    wait_result("t52", 1);
    check_eq("t52_lit_int",   32'(got_int),   32'h00003);
    check_eq("t52_lit_tenth", 32'(got_tenth), 32'd2);
    tick();
    check_eq("t52_idle", 32'(in_ready), 32'd1);

    run_one("t525", 18'd525);
    check_eq("t525_lit_int", 32'(got_int), 32'h00032);
    check_eq("t525_lit_tenth", 32'(got_tenth), 32'd8);
    run_one("t157", 18'd157);
    check_eq("t157_lit_int", 32'(got_int), 32'h00009);
    run_one("tzero", 18'd0);
    check_eq("tzero_lit_int", 32'(got_int), 32'h00000);
    run_one("tmax", 18'h3FFFF);
    check_eq("tmax_lit_int",   32'(got_int),   32'h16383);
    check_eq("tmax_lit_tenth", 32'(got_tenth), 32'd9);
    run_one("t1234", {14'd1234, 4'd7});

    // Stall in DONE for 10 cycles with a competing in_valid
    out_ready = 1'b0;
    feet_in   = {14'd4321, 4'd11};
    in_valid  = 1'b1;
    exp_q.push_back(model(feet_in));
    tick();
    feet_in = {14'd999, 4'd3};
    wait_result("stall", 40);
    for (int k = 0; k < 10; k++) begin
      tick();
      check_eq("stall_valid",    32'(out_valid), 32'd1);
      check_eq("stall_in_ready", 32'(in_ready),  32'd0);
      check_eq("stall_int",      32'(bcd_int),   32'(got_int));
      check_eq("stall_tenth",    32'(bcd_tenth), 32'(got_tenth));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_eq("pulse_idle",  32'(in_ready),  32'd1);
    check_eq("pulse_valid", 32'(out_valid), 32'd0);
    check_eq("pulse_hold_int", 32'(bcd_int), 32'(got_int));
    tick();
    check_eq("pulse_no_start", 32'(busy), 32'd0);

    // Asynchronous reset in CONV cycle 7 discards the conversion
    feet_in  = 18'h3FFFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    check_eq("midrst_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_busy",      32'(busy),      32'd0);
    check_eq("midrst_in_ready",  32'(in_ready),  32'd1);
    check_eq("midrst_bcd_int",   32'(bcd_int),   32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    run_one("post_rst525", 18'd525);
    check_eq("post_rst_lit_int", 32'(got_int), 32'h00032);

    // Back-to-back with in_valid held high: results 16 cycles apart, in order
    vals[0] = {14'd7, 4'd1};
    vals[1] = {14'd10000, 4'd15};
    vals[2] = {14'd86, 4'd8};
    accepted  = 0;
    results   = 0;
    prev_t    = -1;
    prev_busy = busy;
    feet_in   = vals[0];
    in_valid  = 1'b1;
    exp_q.push_back(model(vals[0]));
    for (int c = 0; c < 120 && results < 3; c++) begin
      tick();
      if (busy && !prev_busy) begin
        accepted++;
        if (accepted < 3) begin
          feet_in = vals[accepted];
          exp_q.push_back(model(vals[accepted]));
        end else begin
          in_valid = 1'b0;
        end
      end
      prev_busy = busy;
      if (out_valid) begin
        t = c;
        wait_result("b2b", 0);
        if (prev_t >= 0) check_eq("b2b_spacing", 32'(t - prev_t), 32'd16);
        prev_t = t;
        results++;
      end
    end
    in_valid = 1'b0;
    check_eq("b2b_count", 32'(results), 32'd3);
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/feet_bcd_formatter.md
FEET_BCD_FORMATTER -- requirements
Module: feet_bcd_formatter

Interface
REQ-001 The module SHALL have parameter INT_W, default 14, meaning the integer bit width of the feet input.
REQ-002 The module SHALL have parameter NUM_DIG, default 5, meaning the number of integer BCD digits; it must satisfy 10^NUM_DIG > 2^INT_W - 1.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port feet_in, input, INT_W+4 bits: unsigned feet value in Q(INT_W).4 fixed point, as produced by the upstream meters-to-feet stage.
REQ-006 The module SHALL have port in_valid, input, 1 bit: feet_in is valid.
REQ-007 The module SHALL have port in_ready, output, 1 bit: the block can accept a value.
REQ-008 The module SHALL have port bcd_int, output, 4*NUM_DIG bits: integer part as packed BCD, with the most significant digit in the top nibble.
REQ-009 The module SHALL have port bcd_tenth, output, 4 bits: tenths digit, 0-9.
REQ-010 The module SHALL have port out_valid, input-side-facing output, 1 bit: bcd_int and bcd_tenth are valid.
REQ-011 The module SHALL have port out_ready, input, 1 bit: the downstream display accepts the result.
REQ-012 The module SHALL have port busy, output, 1 bit: a conversion is in progress.

Function
REQ-013 The FSM SHALL have three states: IDLE, CONV and DONE.
REQ-014 In IDLE, in_ready SHALL be 1; on in_valid=1 the block SHALL capture feet_in and go to CONV; otherwise it stays in IDLE.
REQ-015 At capture, the block SHALL compute the tenths digit as floor(frac*10/16), where frac = feet_in[3:0], and hold it unchanged through DONE.
REQ-016 CONV SHALL run the shift-add-3 (double-dabble) algorithm on the integer bits feet_in[INT_W+3:4].
  - Each cycle, every BCD nibble >= 5 gets +3, then one left shift brings in the next integer bit, MSB first.
  - The shift/iteration counter runs exactly INT_W cycles, then the FSM moves to DONE.
REQ-017 in_ready SHALL be 0 in CONV and DONE; busy SHALL be 1 only in CONV.
REQ-018 In DONE, out_valid SHALL be 1 and bcd_int/bcd_tenth SHALL be stable.
  - DONE is held for as long as out_ready=0.
REQ-019 In DONE with out_ready=1, the transfer SHALL complete and the FSM SHALL return to IDLE on the next edge.
  - in_valid in that same cycle is ignored because in_ready=0; a new value is accepted no earlier than the following cycle.
REQ-020 Latency SHALL be INT_W+1 cycles from the accepting edge to out_valid=1; with INT_W=14, out_valid rises on the 15th rising edge after acceptance.
REQ-021 Throughput SHALL be at most one conversion per INT_W+2 cycles when out_ready is held at 1.
REQ-022 bcd_int and bcd_tenth SHALL hold their last result after leaving DONE until the next DONE entry.
  - They are don't-care to consumers whenever out_valid=0.
REQ-023 No output SHALL depend combinationally on in_valid, feet_in or out_ready; all outputs are registered or decoded from state.
REQ-024 Every integer input SHALL fit in NUM_DIG digits with no overflow path: the maximum 16383.9375 gives bcd_int=16383 and bcd_tenth=9.

Reset
REQ-025 On rst_n=0, at any time including mid-CONV or in DONE, the block SHALL asynchronously go to IDLE with in_ready=1, out_valid=0, busy=0, bcd_int=0, bcd_tenth=0 and the counter at 0.
  - Any in-flight conversion is discarded.
REQ-026 After rst_n rises, the block SHALL be able to accept on the first rising edge with in_valid=1.

Verification
REQ-027 The bench SHALL drive feet_in=52 (3.25 ft, from 1 m) with out_ready=1 and check out_valid at edge +15, bcd_int=0x00003 and bcd_tenth=2.
REQ-028 The bench SHALL drive feet_in=525 (32.8125 ft, from 10 m) and check bcd_int=0x00032 and bcd_tenth=8.
  - It SHALL also drive feet_in=157 (9.8125 ft, from 3 m) and check bcd_int=0x00009 and bcd_tenth=8.
REQ-029 The bench SHALL cover both boundaries:
  - feet_in=0 gives bcd_int=0x00000 and bcd_tenth=0.
  - feet_in=0x3FFFF gives bcd_int=0x16383 and bcd_tenth=9.
REQ-030 The bench SHALL hold out_ready=0 for 10 cycles after out_valid rises and check that the outputs stay stable, in_ready=0 and in_valid is ignored.
  - It SHALL then pulse out_ready=1 and check IDLE on the next cycle.
REQ-031 The bench SHALL assert rst_n=0 at CONV cycle 7 and check immediate out_valid=0, busy=0 and in_ready=1.
  - After release, a new value of 525 SHALL convert correctly.
REQ-032 The bench SHALL run back-to-back: in_valid held at 1 with 3 values and out_ready=1 must give 3 results in order, spaced 16 cycles apart.
